housekeeping_spi_sync: RTL and testbench

// Parametrised housekeeping SPI slave that oversamples SCK/CSB/SDI in the system clock

---
 rtl/housekeeping_spi_sync.sv | 251 +++++++++++++++++++++++++
 tb/tb_housekeeping_spi_sync.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/housekeeping_spi_sync.sv
// rtl/housekeeping_spi_sync.sv - oversampled housekeeping SPI slave with single-cycle register strobes
module housekeeping_spi_sync #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCK,
  input  logic              SDI,
  input  logic              CSB,
  output logic              SDO,
  output logic              sdoenb,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] odata,
  output logic [ADDR_W-1:0] oaddr,
  output logic              rdstb,
  output logic              wrstb,
  output logic              pass_thru_mgmt,
  output logic              pass_thru_user,
  output logic              busy,
  output logic              err_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_COMMAND, S_ADDRESS, S_DATA, S_MGMTPASS, S_USERPASS
  } state_t;

  localparam int                CNT_W     = 6;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   sck_s, csb_s, sdi_s, rise, fall;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, cmd_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_next;
  // Holds the first DATA_W-1 bits; the last bit is taken straight from sdi_s.
  logic [DATA_W-2:0] shin_q, shin_d;
  logic [DATA_W-1:0] shout_q, shout_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              rdstb_q, rdstb_d, wrstb_q, wrstb_d;
  logic              err_abort_q, err_abort_d;
  // adv: word just ended, publish the next address one cycle later so that
  // wrstb (old address) and the prefetch rdstb (new address) never overlap.
  logic              adv_q, adv_d, pf_q, pf_d;
  // first: the fall right after a word boundary is skipped while idata loads.
  logic              first_q, first_d;
  logic              pass_mgmt_q, pass_mgmt_d, pass_user_q, pass_user_d;
  logic              sdoenb_q, sdoenb_d;
  logic              abort, last_word;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign rise      = sck_s & ~sck_prev_q;
  assign fall      = ~sck_s & sck_prev_q;
  assign abort     = (state_q != S_IDLE) && csb_s;
  assign last_word = (wcnt_q == 3'd1);
  assign cmd_next  = {cmd_q[6:0], sdi_s};
  assign addr_next = {addr_q[ADDR_W-2:0], sdi_s};

  // Synchroniser shift chains and SCK edge history.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    csb_sync_d = {csb_sync_q[SYNC_STAGES-2:0], CSB};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], SDI};
    sck_prev_d = sck_s;
  end

  // Synchroniser registers; CSB resets to deselected.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q <= '0;
      csb_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      csb_sync_q <= csb_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: deselect wins from any state, otherwise phase progression.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (!csb_s) state_d = S_COMMAND;
        S_COMMAND: begin
          if (rise && (cnt_q == CMD_LAST)) begin
            if (cmd_next[2])      state_d = S_MGMTPASS;
            else if (cmd_next[1]) state_d = S_USERPASS;
            else                  state_d = S_ADDRESS;
          end
        end
        S_ADDRESS: if (rise && (cnt_q == ADDR_LAST)) state_d = S_DATA;
        S_DATA:    if (rise && (cnt_q == DATA_LAST) && last_word) state_d = S_COMMAND;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM outputs and datapath: shifting, strobes, word bookkeeping.
  always_comb begin
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    odata_d     = odata_q;
    oaddr_d     = oaddr_q;
    rdstb_d     = 1'b0;
    wrstb_d     = 1'b0;
    err_abort_d = 1'b0;
    adv_d       = 1'b0;
    pf_d        = 1'b0;
    first_d     = first_q;
    if (abort) begin
      err_abort_d = (state_q == S_DATA) && (cnt_q != '0);
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: cnt_d = '0;
        S_COMMAND: begin
          if (rise) begin
            cmd_d = cmd_next;
            cnt_d = (cnt_q == CMD_LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        S_ADDRESS: begin
          if (rise) begin
            addr_d = addr_next;
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              oaddr_d = addr_next;
              rdstb_d = cmd_q[6];
              wcnt_d  = cmd_q[5:3];
              first_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (adv_q) begin
            oaddr_d = addr_q;
            rdstb_d = pf_q;
          end
          if (rise) begin
            shin_d = {shin_q[DATA_W-3:0], sdi_s};
            if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
              odata_d = {shin_q, sdi_s};
              wrstb_d = cmd_q[7];
              addr_d  = addr_q + ADDR_STEP;
              first_d = 1'b1;
              if (wcnt_q != 3'd0) wcnt_d = wcnt_q - 3'd1;
              adv_d   = !last_word;
              pf_d    = cmd_q[6] && !last_word;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (fall) begin
            if (first_q) first_d = 1'b0;
            else         shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end
        end
        default: cnt_d = '0;
      endcase
    end
    if (rdstb_q) shout_d = idata;
    pass_mgmt_d = (state_d == S_MGMTPASS);
    pass_user_d = (state_d == S_USERPASS);
    sdoenb_d    = !(((state_d == S_DATA) && cmd_q[6]) || pass_mgmt_d || pass_user_d);
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      odata_q     <= '0;
      oaddr_q     <= '0;
      rdstb_q     <= 1'b0;
      wrstb_q     <= 1'b0;
      err_abort_q <= 1'b0;
      adv_q       <= 1'b0;
      pf_q        <= 1'b0;
      first_q     <= 1'b0;
      pass_mgmt_q <= 1'b0;
      pass_user_q <= 1'b0;
      sdoenb_q    <= 1'b1;
    end else begin
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      odata_q     <= odata_d;
      oaddr_q     <= oaddr_d;
      rdstb_q     <= rdstb_d;
      wrstb_q     <= wrstb_d;
      err_abort_q <= err_abort_d;
      adv_q       <= adv_d;
      pf_q        <= pf_d;
      first_q     <= first_d;
      pass_mgmt_q <= pass_mgmt_d;
      pass_user_q <= pass_user_d;
      sdoenb_q    <= sdoenb_d;
    end
  end

  assign SDO            = shout_q[DATA_W-1];
  assign sdoenb         = sdoenb_q;
  assign odata          = odata_q;
  assign oaddr          = oaddr_q;
  assign rdstb          = rdstb_q;
  assign wrstb          = wrstb_q;
  assign pass_thru_mgmt = pass_mgmt_q;
  assign pass_thru_user = pass_user_q;
  assign busy           = (state_q != S_IDLE);
  assign err_abort      = err_abort_q;

endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// tb/tb_housekeeping_spi_sync.sv - scoreboard bench for housekeeping_spi_sync
module tb_housekeeping_spi_sync;

  logic clk = 1'b0;
  logic reset, sck, sdi, csb8, csb32;

  logic        sdo8, sdoenb8, rdstb8, wrstb8, pm8, pu8, busy8, abort8;
  logic [7:0]  idata8, odata8, oaddr8;
  logic        sdo32, sdoenb32, rdstb32, wrstb32, pm32, pu32, busy32, abort32;
  logic [31:0] idata32, odata32;
  logic [15:0] oaddr32;

  int n_checks = 0;
  int n_fail   = 0;
  int abort_exp = 0;
  int sdo_n = 0;
  logic [7:0] sdo_sh;

  logic [63:0] wr8_q[$];
  logic [63:0] rd8_q[$];
  logic [63:0] sdo8_q[$];
  logic [63:0] wr32_q[$];

  // Register file read model: nibble swap then xor.
  function automatic logic [7:0] f8(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  assign idata8  = f8(oaddr8);
  assign idata32 = 32'h0;

  always #5 clk = ~clk;

  housekeeping_spi_sync #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .SCK(sck), .SDI(sdi), .CSB(csb8),
    .SDO(sdo8), .sdoenb(sdoenb8), .idata(idata8), .odata(odata8), .oaddr(oaddr8),
    .rdstb(rdstb8), .wrstb(wrstb8), .pass_thru_mgmt(pm8), .pass_thru_user(pu8),
    .busy(busy8), .err_abort(abort8)
  );

  housekeeping_spi_sync #(.ADDR_W(16), .DATA_W(32), .SYNC_STAGES(3)) dut32 (
    .clk(clk), .reset(reset), .SCK(sck), .SDI(sdi), .CSB(csb32),
    .SDO(sdo32), .sdoenb(sdoenb32), .idata(idata32), .odata(odata32), .oaddr(oaddr32),
    .rdstb(rdstb32), .wrstb(wrstb32), .pass_thru_mgmt(pm32), .pass_thru_user(pu32),
    .busy(busy32), .err_abort(abort32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (wrstb8) begin
      chk("wr8_queued", 64'(wr8_q.size() != 0), 64'd1);
      if (wr8_q.size() != 0) chk("wr8_addr_data", {oaddr8, odata8}, wr8_q.pop_front());
    end
    if (rdstb8) begin
      chk("rd8_queued", 64'(rd8_q.size() != 0), 64'd1);
      if (rd8_q.size() != 0) chk("rd8_addr", oaddr8, rd8_q.pop_front());
      chk("rd8_not_with_wr", wrstb8, 1'b0);
    end
    if (abort8) begin
      chk("abort8_expected", 64'(abort_exp > 0), 64'd1);
      if (abort_exp > 0) abort_exp--;
    end
    if (wrstb32) begin
      chk("wr32_queued", 64'(wr32_q.size() != 0), 64'd1);
      if (wr32_q.size() != 0) chk("wr32_addr_data", {oaddr32, odata32}, wr32_q.pop_front());
    end
    if (rdstb32) chk("rd32_spurious", rdstb32, 1'b0);
    if (abort32) chk("abort32_spurious", abort32, 1'b0);
  end

  // SDO monitor: master samples on SCK rise while the slave drives.
  always @(posedge sck) begin
    if (csb8 || sdoenb8 || pm8 || pu8) begin
      sdo_n = 0;
    end else begin
      sdo_sh = {sdo_sh[6:0], sdo8};
      sdo_n++;
      if (sdo_n == 8) begin
        sdo_n = 0;
        chk("sdo8_queued", 64'(sdo8_q.size() != 0), 64'd1);
        if (sdo8_q.size() != 0) chk("sdo8_word", sdo_sh, sdo8_q.pop_front());
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCK half period of 4 clk cycles.
  task automatic bit_x(input logic b);
    sdi = b;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_x(v[i]);
  endtask

  task automatic cs_set(input bit wide, input logic lvl);
    if (wide) csb32 = lvl;
    else      csb8  = lvl;
  endtask

  task automatic cs_begin(input bit wide);
    cs_set(wide, 1'b0);
    wait_clk(4);
  endtask

  task automatic cs_end(input bit wide);
    wait_clk(4);
    cs_set(wide, 1'b1);
    wait_clk(8);
  endtask

  logic [7:0] pass_cmd [3] = '{8'hC4, 8'hC6, 8'h42};
  logic       pass_m   [3] = '{1'b1, 1'b1, 1'b0};
  logic       pass_u   [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; csb8 = 1'b1; csb32 = 1'b1;
    wait_clk(4);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_sdoenb", sdoenb8, 1'b1);
    chk("rst_sdo", sdo8, 1'b0);
    chk("rst_odata", odata8, 8'h00);
    chk("rst_oaddr", oaddr8, 8'h00);
    chk("rst_strobes", {rdstb8, wrstb8, abort8, pm8, pu8}, 5'b0);
    chk("rst_sdoenb32", sdoenb32, 1'b1);
    reset = 1'b0;
    wait_clk(2);

    // Single 8-bit write.
    wr8_q.push_back(64'h10A5);
    cs_begin(0);
    chk("busy_in_txn", busy8, 1'b1);
    send(8'h88, 8); send(8'h10, 8); send(8'hA5, 8);
    cs_end(0);
    chk("busy_after_write", busy8, 1'b0);
    chk("odata_hold", odata8, 8'hA5);

    // Streaming read across the address wrap; the stream prefetches 0x01 too.
    rd8_q.push_back(64'hFE); rd8_q.push_back(64'hFF);
    rd8_q.push_back(64'h00); rd8_q.push_back(64'h01);
    sdo8_q.push_back(64'hD3); sdo8_q.push_back(64'hC3); sdo8_q.push_back(64'h3C);
    cs_begin(0);
    send(8'h40, 8); send(8'hFE, 8); send(32'h0, 24);
    cs_end(0);
    chk("sdoenb_after_read", sdoenb8, 1'b1);

    // Fixed-count read of 3 words: no prefetch past the last one.
    rd8_q.push_back(64'h7F); rd8_q.push_back(64'h80); rd8_q.push_back(64'h81);
    sdo8_q.push_back(64'hCB); sdo8_q.push_back(64'h34); sdo8_q.push_back(64'h24);
    cs_begin(0);
    send(8'h58, 8); send(8'h7F, 8); send(32'h0, 24);
    cs_end(0);

    // Fixed count of 2 words, then a new command in the same select.
    wr8_q.push_back(64'h2011); wr8_q.push_back(64'h2122); wr8_q.push_back(64'h4033);
    cs_begin(0);
    send(8'h90, 8); send(8'h20, 8); send(8'h11, 8); send(8'h22, 8);
    send(8'h88, 8); send(8'h40, 8); send(8'h33, 8);
    cs_end(0);

    // Command 0x00 clocks through with no strobes.
    cs_begin(0);
    send(8'h00, 8); send(8'h55, 8); send(8'hFF, 8);
    cs_end(0);
    chk("busy_after_nop", busy8, 1'b0);

    // Abort after 5 data bits.
    abort_exp = 1;
    cs_begin(0);
    send(8'h80, 8); send(8'h30, 8); send(32'h16, 5);
    cs_end(0);
    chk("abort_seen", abort_exp, 0);
    chk("busy_after_abort", busy8, 1'b0);
    chk("sdoenb_after_abort", sdoenb8, 1'b1);

    // Pass-through commands.
    for (int k = 0; k < 3; k++) begin
      cs_begin(0);
      send(32'(pass_cmd[k]), 8);
      wait_clk(4);
      chk("pass_mgmt_on", pm8, pass_m[k]);
      chk("pass_user_on", pu8, pass_u[k]);
      chk("pass_sdoenb", sdoenb8, 1'b0);
      send(32'hABCD, 16);
      chk("pass_mgmt_hold", pm8, pass_m[k]);
      chk("pass_user_hold", pu8, pass_u[k]);
      cs_end(0);
      chk("pass_off", {pm8, pu8}, 2'b00);
      chk("pass_sdoenb_off", sdoenb8, 1'b1);
    end

    // 32-bit data, 16-bit address, streaming write.
    wr32_q.push_back(64'h0100_DEADBEEF);
    wr32_q.push_back(64'h0104_12345678);
    cs_begin(1);
    send(8'h80, 8); send(32'h0100, 16); send(32'hDEADBEEF, 32); send(32'h12345678, 32);
    cs_end(1);
    chk("busy32_after", busy32, 1'b0);

    // Reset mid-word overrides CSB: no strobe, no abort.
    cs_begin(0);
    send(8'h88, 8); send(8'h60, 8); send(32'hA, 4);
    reset = 1'b1;
    wait_clk(2);
    chk("busy_in_reset", busy8, 1'b0);
    csb8 = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(8);
    chk("busy_after_reset", busy8, 1'b0);

    wait_clk(10);
    chk("wr8_drained", wr8_q.size(), 0);
    chk("rd8_drained", rd8_q.size(), 0);
    chk("sdo8_drained", sdo8_q.size(), 0);
    chk("wr32_drained", wr32_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
